// File: rtl/seq_cla_adder.sv
// Multi-cycle W-bit adder: streams 16-bit slices of two latched operands, LSB first,
// through a single 16-bit CLA and registers the inter-slice carry.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [16:0] w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = c_in;

    // Four 4-bit lookahead groups; the group carry ripples into the next group.
    for (genvar grp = 0; grp < 4; grp++) begin : g_grp
        localparam int B = 4 * grp;
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    end

    assign sum   = w_p ^ w_c[15:0];
    assign c_out = w_c[16];
endmodule

module seq_cla_adder #(
    parameter int NSLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*NSLICE-1:0] a,
    input  logic [16*NSLICE-1:0] b,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [16*NSLICE-1:0] sum,
    output logic                 c_out,
    output logic                 overflow
);
    localparam int W  = 16 * NSLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_sum;
    logic           r_busy;
    logic           r_done;
    logic           r_c_out;
    logic           r_overflow;

    logic [15:0]    w_cla_sum;
    logic           w_cla_c_out;

    cla16 u_cla (
        .a     (r_a[16*r_idx +: 16]),
        .b     (r_b[16*r_idx +: 16]),
        .c_in  (r_carry),
        .sum   (w_cla_sum),
        .c_out (w_cla_c_out)
    );

    // NOTE: every state register uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[16*r_idx +: 16] <= w_cla_sum;
                    r_carry               <= w_cla_c_out;
                    r_idx                 <= r_idx + IW'(1);
                    if (r_idx == IW'(NSLICE - 1)) begin
                        // Top slice: the fresh slice MSB is the result sign bit.
                        r_c_out    <= w_cla_c_out;
                        r_overflow <= (r_a[W-1] == r_b[W-1]) && (w_cla_sum[15] != r_a[W-1]);
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed-vector bench for seq_cla_adder (NSLICE=4, W=64) with hand-computed results.

module tb_seq_cla_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c_in = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        c_out;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int lat;
    int bcnt;
    int d0;

    seq_cla_adder #(.NSLICE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns on the negedge after the accepted start edge.
    task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vc);
        a = va; b = vb; c_in = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles and cycles until done, bounded at 20 cycles.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_add(input string tag, input logic [63:0] va, input logic [63:0] vb,
                           input logic vc, input logic [63:0] es, input logic ec, input logic eo);
        start_op(va, vb, vc);
        wait_done(lat, bcnt);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, 64'(c_out), 64'(ec));
        check({tag, "_overflow"}, 64'(overflow), 64'(eo));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_sum_held"}, sum, es);
    endtask

    initial begin
        // Reset, then idle for 10 cycles.
        rst = 1'b1;
        #12;
        check("rst_sum", sum, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_sum", sum, 64'd0);
        check("idle_c_out", 64'(c_out), 64'd0);
        check("idle_overflow", 64'(overflow), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_no_done", 64'(done_cnt), 64'd0);

        run_add("full_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
        run_add("cross1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_add("cross3", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
        run_add("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_add("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
        run_add("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0, 1'b0);

        // Start re-pulsed during RUN with new operands must be ignored.
        d0 = done_cnt;
        start_op(64'd12345, 64'd98450, 1'b0);
        start_op(64'd1, 64'd1, 1'b1);
        wait_done(lat, bcnt);
        check("ign_latency", 64'(lat), 64'd3);
        check("ign_sum", sum, 64'd110795);
        check("ign_c_out", 64'(c_out), 64'd0);
        repeat (8) @(negedge clk);
        check("ign_single_done", 64'(done_cnt - d0), 64'd1);
        check("ign_busy_idle", 64'(busy), 64'd0);
        run_add("after_ign", 64'd1, 64'd1, 1'b1, 64'd3, 1'b0, 1'b0);

        // Reset after two RUN edges aborts the add without a done pulse.
        d0 = done_cnt;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_sum", sum, 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("mid_rst_c_out", 64'(c_out), 64'd0);
        run_add("restart", 64'd255, 64'd1111, 1'b0, 64'd1366, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
